data_ram_arbiter: RTL
=====================

DATA_RAM_ARBITER -- requirements
Module: data_ram_arbiter

Interface
REQ-001 SHALL have parameter: MAX_WAIT, 4, cycles a pending DMA request may lose arbitration before it takes priority (range 1..15).
REQ-002 SHALL have ports, one per line:
- clk  in  1  single clock; all state changes on its rising edge.
- rst  in  1  asynchronous active-low reset.
- c_req  in  1  core MEM-stage access request.
- c_we  in  1  core write, 0 = read.
- c_addr  in  32  core byte address.
- c_wdata  in  32  core store data.
- c_ubhw  in  3  core width/sign code (funct3).
- c_cancel  in  1  core write cancel from exception unit.
- c_ack  out  1  core transaction complete.
- c_rdata  out  32  core read data.
- c_fault  out  1  core access fault.
- c_stall  out  1  pipeline stall request.
- d_req  in  1  DMA/debug access request.
- d_we  in  1  DMA write, 0 = read.
- d_addr  in  32  DMA byte address.
- d_wdata  in  32  DMA store data.
- d_ubhw  in  3  DMA width/sign code.
- d_ack  out  1  DMA transaction complete.
- d_rdata  out  32  DMA read data.
- d_fault  out  1  DMA access fault.
- ram_addr  out  32  RAM address.
- ram_din  out  32  RAM write data.
- ram_we  out  1  RAM write strobe.
- ram_re  out  1  RAM read strobe.
- ram_ubhw  out  3  RAM width code.
- ram_dout  in  32  RAM read data, valid the cycle after ram_re.
- ram_fault  in  1  RAM access fault, valid the cycle after a strobe.

Function
REQ-003 SHALL implement FSM IDLE, ISSUE, RESP; each transaction is exactly one ISSUE cycle followed by one RESP cycle.
REQ-004 IDLE: if c_req or d_req, SHALL pick a winner, latch its we/addr/wdata/ubhw and owner ID, and go to ISSUE; else stay in IDLE.
REQ-005 ISSUE: SHALL drive ram_* from the latched fields, assert ram_re for reads or ram_we for writes, then go to RESP.
REQ-006 Outside ISSUE, SHALL hold ram_we=0, ram_re=0, ram_addr=0, ram_din=0, ram_ubhw=0.
REQ-007 RESP: SHALL pulse the owner's ack for one cycle, present ram_dout on the owner's rdata, and present ram_fault on the owner's fault.
REQ-008 Outside the owner's RESP, the rdata output SHALL hold the value captured at the end of that port's last RESP; fault SHALL be 0.
REQ-009 RESP: SHALL arbitrate among requests excluding the port being acked, then go to ISSUE if one wins, else to IDLE. Peak throughput is one transaction per 2 cycles.
REQ-010 Arbitration: core wins by default; DMA wins when d_req=1 and wait_cnt==MAX_WAIT.
REQ-011 wait_cnt SHALL increment, saturating at MAX_WAIT, on each arbitration cycle with d_req=1 where DMA loses; SHALL clear on DMA grant; width $clog2(MAX_WAIT+1).
REQ-012 c_stall SHALL equal c_req & ~c_ack, combinationally.
REQ-013 Requesters SHALL hold req and payload stable until ack; the arbiter latches the payload at grant and ignores later changes.
REQ-014 c_cancel=1 during ISSUE of a core write SHALL force ram_we=0; the transaction SHALL still complete with c_ack. c_cancel SHALL have no effect in any other cycle or on DMA transactions.
REQ-015 Simultaneous c_req and d_req in IDLE with wait_cnt<MAX_WAIT SHALL grant the core.

Reset
REQ-016 rst=0 SHALL asynchronously force: state IDLE, wait_cnt 0, latched fields 0, c_rdata/d_rdata 0, all acks, faults and ram strobes 0.
REQ-017 Reset during ISSUE or RESP SHALL abandon the transaction with no ack.

Structure
REQ-018 The state enum (IDLE/ISSUE/RESP) and owner IDs (OWN_CORE=0, OWN_DMA=1) SHALL live in shared package mem_arb_pkg.
REQ-019 Winner selection and wait_cnt SHALL be one sub-module, mem_arb_starve_ctr.

Verification
REQ-020 Core read only: c_req, c_addr=0x40, RAM holds 0x12345678 -> ram_re in cycle 1, c_ack plus c_rdata=0x12345678 in cycle 2, c_stall=1 in cycles 0-1.
REQ-021 Simultaneous requests in IDLE -> core granted first; DMA ISSUE immediately follows core RESP; d_ack 2 cycles after c_ack.
REQ-022 Core re-requests continuously (back-to-back) with d_req held, MAX_WAIT=4 -> DMA granted no later than its 5th arbitration cycle; wait_cnt returns to 0.
REQ-023 Core write 0xDEADBEEF to 0x80 with c_cancel=1 in ISSUE -> ram_we=0, c_ack still pulses, subsequent read of 0x80 returns old data.
REQ-024 rst=0 asserted mid-RESP of a DMA read -> d_ack never pulses, all outputs 0 immediately, IDLE after release.
REQ-025 ram_fault=1 in RESP of a DMA write -> d_fault=1 with d_ack for one cycle, c_fault stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types for the data RAM arbiter: FSM states, owner IDs, latched request fields.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

    // Owner of the transaction in flight.
    localparam logic OWN_CORE = 1'b0;
    localparam logic OWN_DMA  = 1'b1;

    // Payload captured at grant and replayed onto the RAM port during ISSUE.
    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [2:0]  ubhw;
    } req_fields_t;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Winner selection between core and DMA with a DMA starvation counter.
// Latency: grant is combinational; wait count updates on the clock edge.
// Backpressure: a losing DMA request gains priority after MAX_WAIT lost arbitrations.
//
// Ports:
//   clk_i, rst_ni            clock, asynchronous active-low reset
//   arb_en_i                 this cycle is an arbitration opportunity
//   c_req_i, d_req_i         raw requests from core and DMA
//   excl_en_i, excl_own_i    exclude the given owner (the port currently being acked)
//   grant_vld_o, grant_own_o winner valid and its owner ID
module mem_arb_starve_ctr
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic arb_en_i,
    input  logic c_req_i,
    input  logic d_req_i,
    input  logic excl_en_i,
    input  logic excl_own_i,
    output logic grant_vld_o,
    output logic grant_own_o
);

    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt_q, wait_cnt_d;
    logic          c_elig, d_elig, starved, d_win;

    // A port being acked this cycle does not compete, so it neither wins nor
    // counts as a loss.
    assign c_elig  = c_req_i & ~(excl_en_i & (excl_own_i == OWN_CORE));
    assign d_elig  = d_req_i & ~(excl_en_i & (excl_own_i == OWN_DMA));
    assign starved = (wait_cnt_q == CW'(MAX_WAIT));
    assign d_win   = d_elig & (~c_elig | starved);

    assign grant_vld_o = arb_en_i & (c_elig | d_elig);
    assign grant_own_o = d_win ? OWN_DMA : OWN_CORE;

    always_comb begin
        wait_cnt_d = wait_cnt_q;
        if (arb_en_i) begin
            if (d_win) begin
                wait_cnt_d = '0;
            end else if (d_elig && !starved) begin
                wait_cnt_d = wait_cnt_q + CW'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wait_cnt_q <= '0;
        end else begin
            wait_cnt_q <= wait_cnt_d;
        end
    end

endmodule

// File: rtl/data_ram_arbiter.sv
// Two-port (core, DMA) arbiter onto a single data RAM: IDLE -> ISSUE -> RESP per transaction.
// Latency: request seen in IDLE -> RAM strobe next cycle -> ack/rdata the cycle after.
// Backpressure: core stalls via c_stall until ack; DMA waits on d_ack, promoted after MAX_WAIT losses.
//
// Ports:
//   clk, rst                          clock, asynchronous active-low reset
//   c_* (req/we/addr/wdata/ubhw/cancel in; ack/rdata/fault/stall out)  core MEM-stage port
//   d_* (req/we/addr/wdata/ubhw in; ack/rdata/fault out)              DMA/debug port
//   ram_* (addr/din/we/re/ubhw out; dout/fault in)                     RAM port, 1-cycle response
module data_ram_arbiter
    import mem_arb_pkg::*;
#(
    parameter int MAX_WAIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        c_req,
    input  logic        c_we,
    input  logic [31:0] c_addr,
    input  logic [31:0] c_wdata,
    input  logic [2:0]  c_ubhw,
    input  logic        c_cancel,
    output logic        c_ack,
    output logic [31:0] c_rdata,
    output logic        c_fault,
    output logic        c_stall,
    input  logic        d_req,
    input  logic        d_we,
    input  logic [31:0] d_addr,
    input  logic [31:0] d_wdata,
    input  logic [2:0]  d_ubhw,
    output logic        d_ack,
    output logic [31:0] d_rdata,
    output logic        d_fault,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_din,
    output logic        ram_we,
    output logic        ram_re,
    output logic [2:0]  ram_ubhw,
    input  logic [31:0] ram_dout,
    input  logic        ram_fault
);

    arb_state_e  state_q;
    logic        own_q;
    req_fields_t req_q;
    logic [31:0] c_rdata_q, d_rdata_q;

    logic        in_issue, in_resp;
    logic        grant_vld, grant_own;
    req_fields_t grant_fields;
    logic        cancel_wr;

    assign in_issue = (state_q == ST_ISSUE);
    assign in_resp  = (state_q == ST_RESP);

    // Arbitration happens in IDLE and overlapped with RESP; the owner being
    // acked is excluded so the other port can issue back-to-back.
    mem_arb_starve_ctr #(
        .MAX_WAIT (MAX_WAIT)
    ) u_starve (
        .clk_i       (clk),
        .rst_ni      (rst),
        .arb_en_i    ((state_q == ST_IDLE) | in_resp),
        .c_req_i     (c_req),
        .d_req_i     (d_req),
        .excl_en_i   (in_resp),
        .excl_own_i  (own_q),
        .grant_vld_o (grant_vld),
        .grant_own_o (grant_own)
    );

    always_comb begin
        if (grant_own == OWN_DMA) begin
            grant_fields = '{we: d_we, addr: d_addr, wdata: d_wdata, ubhw: d_ubhw};
        end else begin
            grant_fields = '{we: c_we, addr: c_addr, wdata: c_wdata, ubhw: c_ubhw};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            own_q     <= OWN_CORE;
            req_q     <= '0;
            c_rdata_q <= '0;
            d_rdata_q <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (grant_vld) begin
                        req_q   <= grant_fields;
                        own_q   <= grant_own;
                        state_q <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    state_q <= ST_RESP;
                end
                ST_RESP: begin
                    // Keep the last response visible on the owner's port after ack.
                    if (own_q == OWN_CORE) begin
                        c_rdata_q <= ram_dout;
                    end else begin
                        d_rdata_q <= ram_dout;
                    end
                    if (grant_vld) begin
                        req_q   <= grant_fields;
                        own_q   <= grant_own;
                        state_q <= ST_ISSUE;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    // A core write cancelled by the exception unit still runs its slot and
    // acks, it just never strobes the RAM.
    assign cancel_wr = in_issue & (own_q == OWN_CORE) & c_cancel;

    assign ram_we   = in_issue & req_q.we & ~cancel_wr;
    assign ram_re   = in_issue & ~req_q.we;
    assign ram_addr = in_issue ? req_q.addr  : 32'h0;
    assign ram_din  = in_issue ? req_q.wdata : 32'h0;
    assign ram_ubhw = in_issue ? req_q.ubhw  : 3'h0;

    assign c_ack   = in_resp & (own_q == OWN_CORE);
    assign d_ack   = in_resp & (own_q == OWN_DMA);
    assign c_rdata = c_ack ? ram_dout : c_rdata_q;
    assign d_rdata = d_ack ? ram_dout : d_rdata_q;
    assign c_fault = c_ack & ram_fault;
    assign d_fault = d_ack & ram_fault;
    assign c_stall = c_req & ~c_ack;

endmodule
